// File: rtl/sif_reg_bank.sv
// sif_reg_bank: register bank with a read/write port and a write-only port, with collision, range and protocol error pulses
module sif_reg_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] xa_addr_i,
  input  logic [DATA_W-1:0] xa_data_wr_i,
  input  logic              xa_wr_s_i,
  input  logic              xa_rd_s_i,
  output logic [DATA_W-1:0] xa_data_rd_o,
  output logic              xa_rd_valid_o,
  input  logic [ADDR_W-1:0] wa_addr_i,
  input  logic [DATA_W-1:0] wa_data_wr_i,
  input  logic              wa_wr_s_i,
  output logic              err_addr_o,
  output logic              err_coll_o,
  output logic              err_proto_o,
  output logic [7:0]        coll_cnt_o
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [7:0] cnt_q, cnt_d;
  logic valid_q, eaddr_q, ecoll_q, eproto_q;
  logic xa_ok, wa_ok, xa_wr, xa_rd, wa_wr, coll, proto, addr_err;
  logic [IW-1:0] xa_idx, wa_idx;
  always_comb begin
    xa_idx = xa_addr_i[IW-1:0];
    wa_idx = wa_addr_i[IW-1:0];
    xa_ok = {1'b0, xa_addr_i} < LIM;
    wa_ok = {1'b0, wa_addr_i} < LIM;
    proto = xa_wr_s_i && xa_rd_s_i;
    xa_wr = xa_wr_s_i && !xa_rd_s_i && xa_ok;
    xa_rd = xa_rd_s_i && !xa_wr_s_i;
    wa_wr = wa_wr_s_i && wa_ok;
    coll = xa_wr && wa_wr && (xa_idx == wa_idx);
    addr_err = ((xa_wr_s_i || xa_rd_s_i) && !xa_ok) || (wa_wr_s_i && !wa_ok);
    rd_d = xa_ok ? regs_q[xa_idx] : '0;
    cnt_d = (coll && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
      rd_q <= '0;
      valid_q <= 1'b0;
      eaddr_q <= 1'b0;
      ecoll_q <= 1'b0;
      eproto_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      // xa is applied last so it wins a same-address collision
      if (wa_wr && !coll) regs_q[wa_idx] <= wa_data_wr_i;
      if (xa_wr) regs_q[xa_idx] <= xa_data_wr_i;
      if (xa_rd) rd_q <= rd_d;
      valid_q <= xa_rd;
      eaddr_q <= addr_err;
      ecoll_q <= coll;
      eproto_q <= proto;
      cnt_q <= cnt_d;
    end
  end
  assign xa_data_rd_o = rd_q;
  assign xa_rd_valid_o = valid_q;
  assign err_addr_o = eaddr_q;
  assign err_coll_o = ecoll_q;
  assign err_proto_o = eproto_q;
  assign coll_cnt_o = cnt_q;
endmodule

// File: tb/tb_sif_reg_bank.sv
// tb_sif_reg_bank: directed self-checking bench for sif_reg_bank
module tb_sif_reg_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] xa_addr = '0, xa_wdata = '0, wa_addr = '0, wa_wdata = '0;
  logic xa_wr = 1'b0, xa_rd = 1'b0, wa_wr = 1'b0;
  logic [15:0] rdata;
  logic rvalid, e_addr, e_coll, e_proto;
  logic [7:0] ccnt;
  int checks = 0;
  int errors = 0;

  sif_reg_bank dut (
    .clk_i(clk), .rst_i(rst),
    .xa_addr_i(xa_addr), .xa_data_wr_i(xa_wdata), .xa_wr_s_i(xa_wr), .xa_rd_s_i(xa_rd),
    .xa_data_rd_o(rdata), .xa_rd_valid_o(rvalid),
    .wa_addr_i(wa_addr), .wa_data_wr_i(wa_wdata), .wa_wr_s_i(wa_wr),
    .err_addr_o(e_addr), .err_coll_o(e_coll), .err_proto_o(e_proto), .coll_cnt_o(ccnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] xa, input logic [15:0] xd, input logic xw, input logic xr,
                     input logic [15:0] wa, input logic [15:0] wd, input logic ww);
    xa_addr = xa; xa_wdata = xd; xa_wr = xw; xa_rd = xr;
    wa_addr = wa; wa_wdata = wd; wa_wr = ww;
    @(posedge clk);
    #1;
    xa_wr = 1'b0; xa_rd = 1'b0; wa_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    cyc(a, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    chk({tag, "_valid"}, rvalid, 1);
    chk({tag, "_data"}, rdata, exp);
  endtask

  task automatic chk_errs(input string tag, input logic ea, input logic ec, input logic ep);
    chk({tag, "_err_addr"}, e_addr, ea);
    chk({tag, "_err_coll"}, e_coll, ec);
    chk({tag, "_err_proto"}, e_proto, ep);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", rdata, 0);
    chk("rst_valid", rvalid, 0);
    chk_errs("rst", 0, 0, 0);
    chk("rst_cnt", ccnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(16'(i), 16'h0, "rst_read");
      chk_errs("rst_read", 0, 0, 0);
    end
    cyc(16'd3, 16'h1234, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("wr3_valid", rvalid, 0);
    chk_errs("wr3", 0, 0, 0);
    rd(16'd3, 16'h1234, "rd3");
    cyc(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("idle_valid", rvalid, 0);
    chk("idle_hold", rdata, 16'h1234);
    cyc(16'd5, 16'hAAAA, 1'b1, 1'b0, 16'd5, 16'h5555, 1'b1);
    chk_errs("coll", 0, 1, 0);
    chk("coll_cnt1", ccnt, 1);
    cyc(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("coll_once", e_coll, 0);
    rd(16'd5, 16'hAAAA, "coll_rd5");
    cyc(16'd8, 16'h0111, 1'b1, 1'b0, 16'd9, 16'h0222, 1'b1);
    chk_errs("dual", 0, 0, 0);
    chk("dual_cnt", ccnt, 1);
    rd(16'd8, 16'h0111, "dual_rd8");
    rd(16'd9, 16'h0222, "dual_rd9");
    cyc(16'd2, 16'hFFFF, 1'b1, 1'b1, 16'd7, 16'h0777, 1'b1);
    chk_errs("proto", 0, 0, 1);
    chk("proto_valid", rvalid, 0);
    cyc(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("proto_once", e_proto, 0);
    rd(16'd2, 16'h0, "proto_rd2");
    rd(16'd7, 16'h0777, "proto_rd7");
    cyc(16'd17, 16'h0, 1'b0, 1'b1, 16'd16, 16'hBEEF, 1'b1);
    chk_errs("oor", 1, 0, 0);
    chk("oor_valid", rvalid, 1);
    chk("oor_data", rdata, 0);
    rd(16'd0, 16'h0, "oor_rd0");
    chk("oor_clear", e_addr, 0);
    cyc(16'd20, 16'h9999, 1'b1, 1'b0, 16'd4, 16'h0444, 1'b1);
    chk_errs("oor_xa", 1, 0, 0);
    rd(16'd4, 16'h0444, "oor_rd4");
    cyc(16'h0, 16'h0, 1'b0, 1'b0, 16'd1, 16'h0011, 1'b1);
    cyc(16'd1, 16'h0, 1'b0, 1'b1, 16'd1, 16'h00FF, 1'b1);
    chk("rbw_valid", rvalid, 1);
    chk("rbw_old", rdata, 16'h0011);
    rd(16'd1, 16'h00FF, "rbw_new");
    for (int i = 0; i < 300; i++) begin
      cyc(16'd5, 16'hAAAA, 1'b1, 1'b0, 16'd5, 16'h5555, 1'b1);
      chk("coll_pulse", e_coll, 1);
    end
    chk("coll_sat", ccnt, 255);
    rd(16'd1, 16'h00FF, "pre_rst");
    rst = 1'b1;
    cyc(16'd1, 16'hDEAD, 1'b1, 1'b0, 16'd6, 16'hBEEF, 1'b1);
    chk("mid_rst_data", rdata, 0);
    chk("mid_rst_valid", rvalid, 0);
    chk_errs("mid_rst", 0, 0, 0);
    chk("mid_rst_cnt", ccnt, 0);
    rst = 1'b0;
    cyc(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("post_rst_valid", rvalid, 0);
    rd(16'd1, 16'h0, "post_rst_rd1");
    rd(16'd6, 16'h0, "post_rst_rd6");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sif_reg_bank.md
SIF_REG_BANK -- requirements
Module: sif_reg_bank

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, register and data width in bits (1..32).
REQ-002 SHALL provide parameter ADDR_W, default 16, address bus width (ADDR_W >= clog2(DEPTH)).
REQ-003 SHALL provide parameter DEPTH, default 16, number of registers (2..256).
REQ-004 SHALL provide parameter RST_VAL, default 0, DATA_W-bit reset value of every register.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 xa_addr_i  in  ADDR_W  external-access address.
REQ-008 xa_data_wr_i  in  DATA_W  external-access write data.
REQ-009 xa_wr_s_i  in  1  external-access write strobe, one cycle per write.
REQ-010 xa_rd_s_i  in  1  external-access read strobe, one cycle per read.
REQ-011 xa_data_rd_o  out  DATA_W  read data, valid when xa_rd_valid_o=1.
REQ-012 xa_rd_valid_o  out  1  read-data valid pulse.
REQ-013 wa_addr_i  in  ADDR_W  write-only port address.
REQ-014 wa_data_wr_i  in  DATA_W  write-only port data.
REQ-015 wa_wr_s_i  in  1  write-only port strobe.
REQ-016 err_addr_o  out  1  one-cycle pulse: any strobe with address >= DEPTH.
REQ-017 err_coll_o  out  1  one-cycle pulse: xa and wa write same address same cycle.
REQ-018 err_proto_o  out  1  one-cycle pulse: xa_wr_s_i and xa_rd_s_i both high.
REQ-019 coll_cnt_o  out  8  saturating count of collisions since reset.

Function
REQ-020 SHALL hold DEPTH registers of DATA_W bits; writes take effect at the clock edge sampling the strobe.
REQ-021 xa write: reg[xa_addr_i] <= xa_data_wr_i when xa_wr_s_i=1, xa_rd_s_i=0, address in range.
REQ-022 wa write: reg[wa_addr_i] <= wa_data_wr_i when wa_wr_s_i=1, address in range, no collision loss.
REQ-023 Both ports writing different in-range addresses same cycle SHALL both commit.
REQ-024 Both ports writing same in-range address same cycle: xa data SHALL win, wa write dropped, err_coll_o pulses next cycle, coll_cnt_o increments.
REQ-025 coll_cnt_o SHALL saturate at 255 and never wrap.
REQ-026 xa read: latency exactly 1 cycle; xa_data_rd_o = reg[xa_addr_i] as it was before that edge's writes (read-before-write), xa_rd_valid_o=1 for one cycle.
REQ-027 Read of out-of-range address SHALL return 0 with xa_rd_valid_o=1 and err_addr_o pulse.
REQ-028 Out-of-range write on either port SHALL be ignored with err_addr_o pulse; in-range write on the other port still commits.
REQ-029 xa_wr_s_i=1 and xa_rd_s_i=1 together SHALL be treated as xa idle (no write, no valid), err_proto_o pulses; wa port unaffected.
REQ-030 All error pulses SHALL be registered, asserted the cycle after the offending strobe, one cycle wide; events in consecutive cycles give consecutive pulses.
REQ-031 xa_data_rd_o SHALL hold its last value when xa_rd_valid_o=0.
REQ-032 Back-to-back xa strobes every cycle SHALL be accepted without stall; no backpressure exists.

Reset
REQ-033 While rst_i=1 at an edge: all registers <= RST_VAL, xa_data_rd_o <= 0, xa_rd_valid_o, err_addr_o, err_coll_o, err_proto_o <= 0, coll_cnt_o <= 0.
REQ-034 Strobes sampled while rst_i=1 SHALL be ignored; a read issued the cycle before reset asserts SHALL NOT produce xa_rd_valid_o after reset.
REQ-035 First strobe SHALL be accepted at the first edge with rst_i=0.

Verification
REQ-036 Reset then read all DEPTH addresses -> each returns RST_VAL one cycle after strobe, no error pulses.
REQ-037 xa write 0x1234 to addr 3, read addr 3 next cycle -> xa_data_rd_o=0x1234, xa_rd_valid_o=1 one cycle after the read strobe.
REQ-038 xa writes 0xAAAA and wa writes 0x5555 to addr 5 same cycle -> reg[5]=0xAAAA, err_coll_o pulses once, coll_cnt_o=1; repeat 300 times -> coll_cnt_o=255.
REQ-039 xa write and read strobes together at addr 2 -> err_proto_o pulse, reg[2] unchanged, no valid; concurrent wa write to addr 7 commits.
REQ-040 wa write addr DEPTH and xa read addr DEPTH+1 -> err_addr_o pulse, no register change, read returns 0 with valid.
REQ-041 wa writes 0x00FF to addr 1 in same cycle as xa reads addr 1 (old 0x0011) -> read returns 0x0011; following read returns 0x00FF; rst_i mid-sequence -> all outputs 0 next cycle.
